// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   OP_*        two-bit operation encodings seen on the op port
//   md_state_t  sequencer states
//   MD_DZ_LO    LO value written on divide-by-zero (all ones, sliced to width)
package mips_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;

   localparam logic [63:0] MD_DZ_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
//   is_div    1: restoring-divide step, 0: shift-add multiply step
//   hi, lo    current accumulator halves
//             multiply: hi = partial product upper word, lo = remaining multiplier bits
//             divide:   hi = partial remainder, lo = dividend bits / quotient so far
//   operand   multiplicand magnitude (multiply) or divisor magnitude (divide)
//   hi_next, lo_next  accumulator after this iteration
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] hi_next,
   output logic [WIDTH-1:0] lo_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
      shifted = {hi, lo[WIDTH-1]};
      // Remainder stays below the divisor, so a set top bit here means
      // the trial subtraction went negative.
      trial   = shifted - {1'b0, operand};
      hi_next = '0;
      lo_next = '0;
      if (is_div) begin
         if (!trial[WIDTH]) begin
            hi_next = trial[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_next = shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         // The carry out of the add becomes the new top bit after the shift.
         hi_next = sum[WIDTH:1];
         lo_next = {sum[0], lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//   clk, rst          clock, asynchronous active-high reset
//   start, op, A, B   operation request (sampled only when idle)
//   mthi, mtlo, wdata direct HI/LO writes (idle only, dropped when start is high)
//   busy              operation in progress (registered)
//   done              one-cycle pulse when HI/LO hold a new result
//   div_by_zero       sticky flag from the last divide, cleared on next accept
//   HI, LO            result registers
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | waiting for start; accepts MTHI/MTLO
// MD_CALC | one multiply/divide iteration per cycle, WIDTH cycles
// MD_FIX  | sign correction, HI/LO write, done pulse next cycle
module hilo_muldiv
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic             is_div;
   logic             sign_a;
   logic             sign_b;
   logic             dz_pend;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] operand;

   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   logic               op_is_div;
   logic               op_signed;
   logic               in_sa;
   logic               in_sb;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] product_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      op_is_div   = (op == OP_DIV) || (op == OP_DIVU);
      op_signed   = !((op == OP_MULTU) || (op == OP_DIVU));
      in_sa       = op_signed & A[WIDTH-1];
      in_sb       = op_signed & B[WIDTH-1];
      mag_a       = in_sa ? -A : A;
      mag_b       = in_sb ? -B : B;
      product     = {acc_hi, acc_lo};
      product_fix = (sign_a ^ sign_b) ? -product : product;
      quot_fix    = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
      // Remainder follows the dividend's sign.
      rem_fix     = sign_a ? -acc_hi : acc_hi;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .hi      (acc_hi),
      .lo      (acc_lo),
      .operand (operand),
      .hi_next (step_hi),
      .lo_next (step_lo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= MD_IDLE;
         cnt         <= '0;
         is_div      <= 1'b0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         dz_pend     <= 1'b0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         operand     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         HI          <= '0;
         LO          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            MD_IDLE: begin
               if (start) begin
                  div_by_zero <= 1'b0;
                  is_div      <= op_is_div;
                  sign_a      <= in_sa;
                  sign_b      <= in_sb;
                  cnt         <= '0;
                  busy        <= 1'b1;
                  acc_hi      <= '0;
                  if (op_is_div) begin
                     operand <= mag_b;
                     if (B == '0) begin
                        // Raw dividend parked in acc_lo for the HI write in FIX.
                        dz_pend <= 1'b1;
                        acc_lo  <= A;
                        state   <= MD_FIX;
                     end else begin
                        dz_pend <= 1'b0;
                        acc_lo  <= mag_a;
                        state   <= MD_CALC;
                     end
                  end else begin
                     dz_pend <= 1'b0;
                     acc_lo  <= mag_b;
                     operand <= mag_a;
                     state   <= MD_CALC;
                  end
               end else begin
                  if (mthi) HI <= wdata;
                  if (mtlo) LO <= wdata;
               end
            end
            MD_CALC: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_LAST) state <= MD_FIX;
            end
            MD_FIX: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= MD_IDLE;
               if (dz_pend) begin
                  HI          <= acc_lo;
                  LO          <= MD_DZ_LO[WIDTH-1:0];
                  div_by_zero <= 1'b1;
               end else if (is_div) begin
                  HI <= rem_fix;
                  LO <= quot_fix;
               end else begin
                  HI <= product_fix[2*WIDTH-1:WIDTH];
                  LO <= product_fix[WIDTH-1:0];
               end
            end
            default: begin
               state <= MD_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_cmp = 0;
   int n_err = 0;

   hilo_muldiv #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .A           (op_a),
      .B           (op_b),
      .mthi        (mthi),
      .mtlo        (mtlo),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .HI          (HI),
      .LO          (LO)
   );

   always #5 clk = ~clk;

   // Reference: plain 64-bit arithmetic, truncating division.
   function automatic void ref_model(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] hi,
                                     output logic [31:0] lo, output logic dz,
                                     output int lat);
      longint      sa, sb, p, q, r;
      logic [63:0] u;
      dz  = 1'b0;
      lat = 33;
      hi  = '0;
      lo  = '0;
      case (o)
         OP_MULT: begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
         end
         OP_MULTU: begin
            u  = {32'b0, a} * {32'b0, b};
            hi = u[63:32];
            lo = u[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               dz  = 1'b1;
               lat = 1;
               hi  = a;
               lo  = 32'hFFFF_FFFF;
            end else if (o == OP_DIV) begin
               sa = $signed(a);
               sb = $signed(b);
               q  = sa / sb;
               r  = sa % sb;
               lo = q[31:0];
               hi = r[31:0];
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      op_a  = a;
      op_b  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_cmp++; if (HI !== 32'd0)       begin n_err++; $display("FAIL reset_hi got %h want 0", HI); end
      n_cmp++; if (LO !== 32'd0)       begin n_err++; $display("FAIL reset_lo got %h want 0", LO); end
      n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
      rst = 1'b0;
   endtask

   task automatic test_directed;
      int lat;
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL multu_lat got %0d want 33", lat); end
      n_cmp++; if (HI !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", HI); end
      n_cmp++; if (LO !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", LO); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL multu_busy_end got %b want 0", busy); end

      run_op(OP_MULT, -32'sd3, 32'd7, lat);
      n_cmp++; if (HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", HI); end
      n_cmp++; if (LO !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got %h want ffffffeb", LO); end

      run_op(OP_DIV, -32'sd7, 32'd2, lat);
      n_cmp++; if (LO !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", LO); end
      n_cmp++; if (HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", HI); end

      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      n_cmp++; if (LO !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo got %h want 80000000", LO); end
      n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL divovf_hi got %h want 0", HI); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL divovf_dz got %b want 0", div_by_zero); end

      run_op(OP_DIVU, 32'd100, 32'd0, lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dz_lat got %0d want 1", lat); end
      n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
      n_cmp++; if (HI !== 32'd100) begin n_err++; $display("FAIL dz_hi got %h want 64", HI); end
      n_cmp++; if (LO !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_lo got %h want ffffffff", LO); end

      run_op(OP_MULTU, 32'd2, 32'd3, lat);
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_clear got %b want 0", div_by_zero); end
      n_cmp++; if (LO !== 32'd6) begin n_err++; $display("FAIL dz_next_lo got %h want 6", LO); end
   endtask

   task automatic test_mthi_mtlo;
      int lat;
      @(negedge clk); mthi = 1'b1; wdata = 32'h1111_2222;
      @(posedge clk); #1; mthi = 1'b0;
      n_cmp++; if (HI !== 32'h1111_2222) begin n_err++; $display("FAIL mthi got %h want 11112222", HI); end
      @(negedge clk); mtlo = 1'b1; wdata = 32'hABCD_0123;
      @(posedge clk); #1; mtlo = 1'b0;
      n_cmp++; if (LO !== 32'hABCD_0123) begin n_err++; $display("FAIL mtlo got %h want abcd0123", LO); end
      n_cmp++; if (HI !== 32'h1111_2222) begin n_err++; $display("FAIL mtlo_hi_kept got %h want 11112222", HI); end
      @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h3333_4444;
      @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
      n_cmp++; if (HI !== 32'h3333_4444) begin n_err++; $display("FAIL both_hi got %h want 33334444", HI); end
      n_cmp++; if (LO !== 32'h3333_4444) begin n_err++; $display("FAIL both_lo got %h want 33334444", LO); end
      // start with a simultaneous MTHI: the write must be dropped
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; op_a = 32'd2; op_b = 32'd3;
      mthi = 1'b1; wdata = 32'h5555_5555;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0;
      n_cmp++; if (HI !== 32'h3333_4444) begin n_err++; $display("FAIL start_wins_hi got %h want 33334444", HI); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL accept_busy got %b want 1", busy); end
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); #1; lat++;
         if (done) break;
      end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL start_wins_lat got %0d want 33", lat); end
      n_cmp++; if (HI !== 32'd0 || LO !== 32'd6) begin n_err++; $display("FAIL start_wins_res got %h_%h want 0_6", HI, LO); end
   endtask

   task automatic test_busy_ignore;
      int lat;
      @(negedge clk);
      start = 1'b1; op = OP_MULT; op_a = 32'd5; op_b = 32'd5;
      @(posedge clk); #1; start = 1'b0;
      lat = 0;
      repeat (5) begin @(posedge clk); #1; lat++; end
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; op_a = 32'd9; op_b = 32'd0;
      mthi = 1'b1; wdata = 32'h0000_DEAD;
      @(posedge clk); #1; lat++;
      start = 1'b0; mthi = 1'b0;
      n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL busy_mthi got %h want 0", HI); end
      while (lat < 100) begin
         @(posedge clk); #1; lat++;
         if (done) break;
      end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL busy_ign_lat got %0d want 33", lat); end
      n_cmp++; if (LO !== 32'd25) begin n_err++; $display("FAIL busy_ign_lo got %h want 19", LO); end
      n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL busy_ign_hi got %h want 0", HI); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL busy_ign_dz got %b want 0", div_by_zero); end
      // the extra start must not have launched a second operation
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_ign_idle got %b want 0", busy); end
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [31:0] ehi, elo;
      logic edz;
      int elat;
      run_op(OP_DIVU, 32'd1000, 32'd7, lat);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done got %b want 1", done); end
      // run_op raises start in the same cycle done is high
      run_op(OP_MULT, 32'hFFFF_FFF0, 32'h0000_0100, lat);
      ref_model(OP_MULT, 32'hFFFF_FFF0, 32'h0000_0100, ehi, elo, edz, elat);
      n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL b2b_lat got %0d want %0d", lat, elat); end
      n_cmp++; if (HI !== ehi || LO !== elo) begin n_err++; $display("FAIL b2b_res got %h_%h want %h_%h", HI, LO, ehi, elo); end
   endtask

   task automatic test_random;
      int lat, elat;
      logic [1:0]  o;
      logic [31:0] a, b, ehi, elo;
      logic edz;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         ref_model(o, a, b, ehi, elo, edz, elat);
         run_op(o, a, b, lat);
         n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL rnd%0d_lat op=%0d got %0d want %0d", i, o, lat, elat); end
         n_cmp++; if (HI !== ehi) begin n_err++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, o, a, b, HI, ehi); end
         n_cmp++; if (LO !== elo) begin n_err++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, o, a, b, LO, elo); end
         n_cmp++; if (div_by_zero !== edz) begin n_err++; $display("FAIL rnd%0d_dz got %b want %b", i, div_by_zero, edz); end
      end
   endtask

   task automatic test_reset_mid;
      logic seen_done;
      @(negedge clk);
      start = 1'b1; op = OP_MULT; op_a = 32'd5; op_b = 32'd5;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_cmp++; if (HI !== 32'd0 || LO !== 32'd0) begin n_err++; $display("FAIL rstmid_hilo got %h_%h want 0_0", HI, LO); end
      @(negedge clk); rst = 1'b0;
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", seen_done); end
      n_cmp++; if (LO !== 32'd0) begin n_err++; $display("FAIL rstmid_lo_after got %h want 0", LO); end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_mthi_mtlo;
      test_busy_ignore;
      test_back_to_back;
      test_random;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
